scs8hd_rr_arb4_ctl: RTL and testbench
=====================================

# scs8hd_rr_arb4_ctl

Four-requester round-robin arbiter that shares one downstream resource, such as a shared driver or bus segment, among four clients. It exports the combinational "any request and enabled" term X = (REQ[0]|REQ[1]|REQ[2]|REQ[3]) & EN, which is the same OR4-AND function as the o41a cell. It also provides a registered one-hot grant with hold, preemption and rotating priority. The block sits between the client request lines and the resource's enable/select inputs.

## Interface
- MAXHOLD, default 8: maximum consecutive grant cycles before forced rotation when others wait. Range 0..255; 0 means unlimited hold.
- CLK  input  1  rising-edge clock
- RESETB  input  1  asynchronous active-low reset
- REQ  input  4  request per client; a client holds it high while it wants the resource
- EN  input  1  global arbitration enable; low forces release and blocks new grants
- X  output  1  combinational (|REQ) & EN
- GNT  output  4  registered one-hot grant, all-zero when idle
- GID  output  2  registered index of the current/last granted client
- BUSY  output  1  registered, equals |GNT

## Operation
- State: IDLE or GRANT. Internal state:
  - ptr[1:0]: highest-priority client.
  - cnt[7:0]: hold counter.
- Reset (RESETB low, asynchronous): state=IDLE, GNT=0000, GID=0, BUSY=0, ptr=0, cnt=0. X remains combinational.
- IDLE: if EN=1 and |REQ, pick the first set REQ bit searching ptr, ptr+1, … circularly (mod 4). Next edge: GNT=onehot(i), GID=i, BUSY=1, cnt=0, state=GRANT. Otherwise stay in IDLE with outputs unchanged (GID keeps its last value).
- GRANT holding client i, evaluated each edge in this priority order:
  1. EN=0: release.
  2. REQ[i]=0: release.
  3. MAXHOLD≠0, cnt==MAXHOLD-1 and any REQ[j≠i]=1: release (preempt).
  4. Otherwise stay; cnt increments, saturating at MAXHOLD-1 (at 255 when MAXHOLD=0).
- Release: next edge GNT=0000, BUSY=0, ptr=(i+1) mod 4 (3 wraps to 0), state=IDLE, GID unchanged.
- Never more than one GNT bit set; GNT changes only at a clock edge or on reset.
- REQ of non-holders is ignored during GRANT except for the preemption check.

## Timing
- X: zero-cycle combinational path from REQ/EN.
- Grant latency: REQ sampled high in IDLE gives GNT one edge later.
- Release latency: REQ[i] or EN low sampled at edge N gives GNT=0 after edge N.
- Mandatory one idle cycle (GNT=0000) between consecutive grants, including back-to-back grants to different clients and re-grant to the same client.
- Hold duration:
  - Lone requester: held indefinitely.
  - MAXHOLD=M with another client waiting: GNT[i] high for exactly M cycles, then a one-cycle gap, then the next client in rotation.
  - MAXHOLD=1 with contention: grant, gap, grant, gap… strict rotation.
- Simultaneous events:
  - EN drop and preemption in the same cycle: treated as a single release; ptr advances once.
  - REQ[i] drop on the preemption cycle: ordinary release, same result.
- Reset mid-grant: GNT clears immediately (asynchronous); ptr returns to 0.

## Test plan
- Reset: RESETB=0 with REQ=1111, EN=1 -> GNT=0000, BUSY=0, GID=0, X=1. Release RESETB -> GNT=0001 one edge later.
- Rotation: REQ=1111, EN=1, MAXHOLD=2 -> GNT sequence 0001,0001,0000,0010,0010,0000,0100,0100,0000,1000,1000,0000,0001 (3→0 wrap).
- Lone hold: REQ=0100 for 20 cycles, MAXHOLD=2 -> GNT=0100 throughout after the first edge. Drop REQ[2] -> GNT=0000 next edge; ptr=3, so a subsequent REQ=1001 grants 1000.
- EN gating: grant active on client 1; EN=0 -> X=0 immediately, GNT=0000 after next edge. REQ=0010 with EN held low -> no grant. EN=1 -> GNT=0010 one edge later.
- MAXHOLD=0: REQ=0011 for 300 cycles -> GNT=0001 continuously, with no preemption and no counter wrap.
- Async reset mid-grant: pulse RESETB low between edges while GNT=1000 -> GNT=0000 before the next edge; ptr=0, so REQ=1001 then grants 0001.

Source files
------------

// File: rtl/scs8hd_rr_arb4_ctl.sv
// Four-client round-robin arbiter with a registered one-hot grant.
// Grants can be held, are preempted after MAXHOLD cycles, and the combinational X term is exported.
module scs8hd_rr_arb4_ctl #(
    parameter int unsigned MAXHOLD = 8
) (
    input  logic       CLK,
    input  logic       RESETB,
    input  logic [3:0] REQ,
    input  logic       EN,
    output logic       X,
    output logic [3:0] GNT,
    output logic [1:0] GID,
    output logic       BUSY
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Hold counter ceiling; with MAXHOLD=0 it only saturates, so it never wraps.
    localparam logic [7:0] CNT_SAT    = (MAXHOLD == 32'd0) ? 8'd255 : 8'(MAXHOLD - 32'd1);
    localparam logic       PREEMPT_EN = (MAXHOLD != 32'd0);

    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (req[idx] && !found) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

    logic [0:0] state_r, state_s;
    logic [1:0] ptr_r, ptr_s;
    logic [7:0] cnt_r, cnt_s;
    logic [3:0] gnt_r, gnt_s;
    logic [1:0] gid_r, gid_s;
    logic       busy_r, busy_s;
    logic [1:0] pick_s;
    logic       others_s;
    logic       release_s;

    assign X = (|REQ) & EN;

    // Next-state and next-output computation for the IDLE/GRANT controller.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        cnt_s     = cnt_r;
        gnt_s     = gnt_r;
        gid_s     = gid_r;
        busy_s    = busy_r;
        pick_s    = rr_pick(REQ, ptr_r);
        // gid_r always names the holder while in GRANT.
        others_s  = |(REQ & ~gnt_r);
        release_s = !EN || !REQ[gid_r] || (PREEMPT_EN && (cnt_r == CNT_SAT) && others_s);
        case (state_r)
            ST_IDLE: begin
                if (EN && (|REQ)) begin
                    state_s = ST_GRANT;
                    gnt_s   = onehot4(pick_s);
                    gid_s   = pick_s;
                    busy_s  = 1'b1;
                    cnt_s   = 8'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    state_s = ST_IDLE;
                    gnt_s   = 4'b0000;
                    busy_s  = 1'b0;
                    ptr_s   = gid_r + 2'd1;
                end else if (cnt_r != CNT_SAT) begin
                    cnt_s = cnt_r + 8'd1;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = 4'b0000;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by RESETB.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_r <= ST_IDLE;
            ptr_r   <= 2'd0;
            cnt_r   <= 8'd0;
            gnt_r   <= 4'b0000;
            gid_r   <= 2'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            gnt_r   <= gnt_s;
            gid_r   <= gid_s;
            busy_r  <= busy_s;
        end
    end

    assign GNT  = gnt_r;
    assign GID  = gid_r;
    assign BUSY = busy_r;

endmodule

// File: tb/tb_scs8hd_rr_arb4_ctl.sv
// Bench for scs8hd_rr_arb4_ctl: three instances (MAXHOLD 2, 0, 1) share stimulus and are
// compared every cycle against a behavioural model, plus literal expectations from directed scenarios.
module tb_scs8hd_rr_arb4_ctl;

    logic       CLK;
    logic       RESETB;
    logic [3:0] REQ;
    logic       EN;
    logic       x_o    [3];
    logic [3:0] gnt_o  [3];
    logic [1:0] gid_o  [3];
    logic       busy_o [3];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        scs8hd_rr_arb4_ctl #(.MAXHOLD((g == 0) ? 2 : ((g == 1) ? 0 : 1))) u_dut (
            .CLK   (CLK),
            .RESETB(RESETB),
            .REQ   (REQ),
            .EN    (EN),
            .X     (x_o[g]),
            .GNT   (gnt_o[g]),
            .GID   (gid_o[g]),
            .BUSY  (busy_o[g])
        );
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int mh(input int d);
        mh = (d == 0) ? 2 : ((d == 1) ? 0 : 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Behavioural model: who holds the resource, for how many cycles, and whose turn is next.
    int holder [3];
    int held   [3];
    int ptr    [3];
    int lastid [3];

    always @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            for (int d = 0; d < 3; d++) begin
                holder[d] = -1; held[d] = 0; ptr[d] = 0; lastid[d] = 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (holder[d] < 0) begin
                    if (EN && REQ != 4'b0000) begin
                        for (int k = 3; k >= 0; k--) begin
                            if (REQ[(ptr[d] + k) % 4]) holder[d] = (ptr[d] + k) % 4;
                        end
                        lastid[d] = holder[d];
                        held[d]   = 1;
                    end
                end else begin
                    if (!EN || !REQ[holder[d]] ||
                        (mh(d) != 0 && held[d] >= mh(d) && (REQ & ~(4'b0001 << holder[d])) != 4'b0000)) begin
                        ptr[d]    = (holder[d] + 1) % 4;
                        holder[d] = -1;
                    end else begin
                        held[d]++;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all instances against the model, away from the active edge.
    always @(negedge CLK) begin
        for (int d = 0; d < 3; d++) begin
            check($sformatf("model_gnt[%0d]", d), 32'(gnt_o[d]),
                  (holder[d] >= 0) ? 32'(4'b0001 << holder[d]) : 32'd0);
            check($sformatf("model_gid[%0d]", d), 32'(gid_o[d]), 32'(lastid[d]));
            check($sformatf("model_busy[%0d]", d), 32'(busy_o[d]), (holder[d] >= 0) ? 32'd1 : 32'd0);
            check($sformatf("model_x[%0d]", d), 32'(x_o[d]), 32'((REQ != 4'b0000) && EN));
        end
    end

    logic [3:0] rot_seq  [13];
    logic [3:0] rot1_seq [8];
    logic [3:0] rq;
    logic       en_r;

    initial begin
        rot_seq  = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                     4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        rot1_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};

        // Reset with all clients requesting.
        RESETB = 1'b0; REQ = 4'b1111; EN = 1'b1;
        adv(2);
        check("rst_gnt", 32'(gnt_o[0]), 32'h0);
        check("rst_busy", 32'(busy_o[0]), 32'h0);
        check("rst_gid", 32'(gid_o[0]), 32'h0);
        check("rst_x", 32'(x_o[0]), 32'h1);
        RESETB = 1'b1;

        // Rotation with all requesting.
        for (int k = 0; k < 13; k++) begin
            adv(1);
            check($sformatf("rot_m2[%0d]", k), 32'(gnt_o[0]), 32'(rot_seq[k]));
            if (k < 8) check($sformatf("rot_m1[%0d]", k), 32'(gnt_o[2]), 32'(rot1_seq[k]));
            check($sformatf("rot_m0[%0d]", k), 32'(gnt_o[1]), 32'h1);
        end

        // Lone requester holds indefinitely; release moves ptr past it.
        REQ = 4'b0000;
        adv(3);
        REQ = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            adv(1);
            for (int d = 0; d < 3; d++) check($sformatf("lone[%0d]", d), 32'(gnt_o[d]), 32'h4);
        end
        REQ = 4'b0000;
        adv(1);
        check("lone_rel", 32'(gnt_o[0]), 32'h0);
        REQ = 4'b1001;
        adv(1);
        for (int d = 0; d < 3; d++) check($sformatf("ptr3[%0d]", d), 32'(gnt_o[d]), 32'h8);

        // EN gating.
        REQ = 4'b0000;
        adv(2);
        REQ = 4'b0010;
        adv(1);
        check("en_grant", 32'(gnt_o[0]), 32'h2);
        EN = 1'b0;
        #1;
        check("en_x_low", 32'(x_o[0]), 32'h0);
        adv(1);
        check("en_rel", 32'(gnt_o[0]), 32'h0);
        for (int k = 0; k < 3; k++) begin
            adv(1);
            check("en_block", 32'(gnt_o[0]), 32'h0);
        end
        EN = 1'b1;
        adv(1);
        check("en_regrant", 32'(gnt_o[0]), 32'h2);

        // Asynchronous reset mid-grant.
        REQ = 4'b0000;
        adv(2);
        REQ = 4'b1000;
        adv(1);
        check("ar_pre", 32'(gnt_o[0]), 32'h8);
        RESETB = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("ar_gnt[%0d]", d), 32'(gnt_o[d]), 32'h0);
            check($sformatf("ar_busy[%0d]", d), 32'(busy_o[d]), 32'h0);
            check($sformatf("ar_gid[%0d]", d), 32'(gid_o[d]), 32'h0);
        end
        RESETB = 1'b1;
        REQ = 4'b1001;
        adv(1);
        for (int d = 0; d < 3; d++) check($sformatf("ar_ptr0[%0d]", d), 32'(gnt_o[d]), 32'h1);

        // Unlimited hold under contention.
        REQ = 4'b0011;
        for (int k = 0; k < 300; k++) begin
            adv(1);
            check("mh0_hold", 32'(gnt_o[1]), 32'h1);
        end

        // Randomized traffic with sticky requests and occasional async reset.
        rq = 4'b0000; en_r = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) en_r = ($urandom_range(0, 3) != 0);
            REQ = rq;
            EN  = en_r;
            if ($urandom_range(0, 299) == 0) begin
                RESETB = 1'b0;
                #1;
                RESETB = 1'b1;
            end
            adv(1);
        end

        adv(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
